// File: rtl/lcd_pkg.sv
// Shared command codes, bit positions, error indices and FSM states for the LCD bus
// responder and its shadow DDRAM.
package lcd_pkg;

  localparam int unsigned CELLS = 32;

  localparam logic [7:0] CMD_CLR     = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNCSET = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam int unsigned ENTRY_SH_BIT = 0;
  localparam int unsigned ENTRY_ID_BIT = 1;
  localparam int unsigned DISP_D_BIT   = 2;
  localparam int unsigned FUNC_DL_BIT  = 4;

  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [6:0] LINE2_BASE = 7'h40;

  localparam int unsigned ERR_BUSY  = 0;
  localparam int unsigned ERR_RW    = 1;
  localparam int unsigned ERR_UNSUP = 2;
  localparam int unsigned ERR_ADDR  = 3;

  typedef enum logic [1:0] {StIdle, StExec, StClearSweep, StWait} lcd_state_e;

  // An instruction belongs to group `base` when its highest set bit is the bit of `base`.
  function automatic logic cmd_is(input logic [7:0] code, input logic [7:0] base);
    logic [7:0] above;
    above = ~((base << 1) - 8'd1);
    return ((code & above) == 8'd0) && ((code & base) != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 character shadow: one write port, registered read port, reset fills with spaces.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [4:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [CELLS];
  logic [7:0] r_rdata;

  // Read samples the array before this edge's write, so a same-cell collision returns old data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(CELLS); i++) r_mem[i] <= SPACE;
      r_rdata <= SPACE;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_receptor.sv
// HD44780-style LCD bus responder: decodes writer strobes into a 2x16 character shadow
// plus cursor, display-on, busy and sticky error state.
module lcd_receptor
  import lcd_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 82000,
  parameter int unsigned CMD_CYCLES   = 2000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_ON,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic [4:0] CURSOR,
  output logic       DISP_ON,
  output logic       BUSY,
  output logic       CMD_VALID,
  output logic [8:0] CMD_CODE,
  output logic [3:0] ERR
);

  localparam int unsigned MaxCycles = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic            r_en;
  logic            r_rs;
  logic            r_rw;
  logic [7:0]      r_data;
  lcd_state_e      r_state;
  logic [CntW-1:0] r_cnt;
  logic [4:0]      r_sweep;
  logic [4:0]      r_cursor;
  logic            r_inc;
  logic            r_disp_on;
  logic            r_busy;
  logic            r_clear;
  logic            r_cmd_valid;
  logic [8:0]      r_cmd_code;
  logic [3:0]      r_err;

  logic       w_fall;
  logic       w_accept;
  logic       w_we;
  logic [4:0] w_waddr;
  logic [7:0] w_wdata;
  logic [6:0] w_ddram_a;

  // The transfer uses the bus values registered during the last EN-high cycle.
  assign w_fall    = r_en & ~LCD_EN & LCD_ON;
  assign w_accept  = w_fall & ~r_busy & ~r_rw;
  assign w_ddram_a = r_data[6:0];

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_cursor;
    w_wdata = r_data;
    if (r_state == StClearSweep) begin
      w_we    = 1'b1;
      w_waddr = r_sweep;
      w_wdata = SPACE;
    end else if (w_accept && r_rs) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_rw        <= 1'b0;
      r_data      <= '0;
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_sweep     <= '0;
      r_cursor    <= '0;
      r_inc       <= 1'b1;
      r_disp_on   <= 1'b0;
      r_busy      <= 1'b0;
      r_clear     <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= '0;
      r_err       <= '0;
    end else begin
      r_en        <= LCD_EN;
      r_rs        <= LCD_RS;
      r_rw        <= LCD_RW;
      r_data      <= LCD_DATA;
      r_cmd_valid <= 1'b0;
      if (w_fall && r_busy) r_err[ERR_BUSY] <= 1'b1;
      if (w_fall && !r_busy && r_rw) r_err[ERR_RW] <= 1'b1;

      if (r_state == StIdle) begin
        if (w_accept) begin
          r_cmd_valid <= 1'b1;
          r_cmd_code  <= {r_rs, r_data};
          r_busy      <= 1'b1;
          r_state     <= StExec;
          r_clear     <= 1'b0;
          r_sweep     <= '0;
          r_cnt       <= CntW'(CMD_CYCLES - 1);
          if (r_rs) begin
            // 5-bit wrap gives 15->16, 31->0 and 0->31, 16->15 for free.
            r_cursor <= r_inc ? r_cursor + 5'd1 : r_cursor - 5'd1;
          end else if (cmd_is(r_data, CMD_CLR)) begin
            r_clear  <= 1'b1;
            r_cursor <= '0;
            r_inc    <= 1'b1;
            r_cnt    <= CntW'(CLEAR_CYCLES - 1);
          end else if (cmd_is(r_data, CMD_HOME)) begin
            r_cursor <= '0;
            r_cnt    <= CntW'(CLEAR_CYCLES - 1);
          end else if (cmd_is(r_data, CMD_ENTRY)) begin
            r_inc <= r_data[ENTRY_ID_BIT];
            if (r_data[ENTRY_SH_BIT]) r_err[ERR_UNSUP] <= 1'b1;
          end else if (cmd_is(r_data, CMD_DISPCTL)) begin
            r_disp_on <= r_data[DISP_D_BIT];
          end else if (cmd_is(r_data, CMD_FUNCSET)) begin
            if (!r_data[FUNC_DL_BIT]) r_err[ERR_UNSUP] <= 1'b1;
          end else if (cmd_is(r_data, CMD_DDRAM)) begin
            if (w_ddram_a[6:4] == 3'b000) begin
              r_cursor <= {1'b0, w_ddram_a[3:0]};
            end else if ((w_ddram_a & 7'h70) == LINE2_BASE) begin
              r_cursor <= {1'b1, w_ddram_a[3:0]};
            end else begin
              r_err[ERR_ADDR] <= 1'b1;
            end
          end else if (cmd_is(r_data, CMD_CGRAM) || r_data == 8'h00) begin
            r_err[ERR_UNSUP] <= 1'b1;
          end
          // Cursor/display shift (CMD_SHIFT group) is accepted with no effect.
        end
      end else if (r_cnt == '0) begin
        r_busy  <= 1'b0;
        r_state <= StIdle;
      end else begin
        r_cnt <= r_cnt - CntW'(1);
        case (r_state)
          StExec:       r_state <= r_clear ? StClearSweep : StWait;
          StClearSweep: begin
            r_sweep <= r_sweep + 5'd1;
            if (r_sweep == 5'(CELLS - 1)) r_state <= StWait;
          end
          default: ;
        endcase
      end
    end
  end

  lcd_ddram u_ddram (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (RD_ADDR),
    .o_rdata (RD_CHAR)
  );

  assign CURSOR    = r_cursor;
  assign DISP_ON   = r_disp_on;
  assign BUSY      = r_busy;
  assign CMD_VALID = r_cmd_valid;
  assign CMD_CODE  = r_cmd_code;
  assign ERR       = r_err;

endmodule

// File: tb/tb_lcd_receptor.sv
// Bench for lcd_receptor: directed bus sequences and random transfers checked against a
// behavioural model of the 2x16 display, cursor, busy time and error flags.
module tb_lcd_receptor;

  localparam int unsigned ClearCycles = 50;
  localparam int unsigned CmdCycles   = 6;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic [7:0] LCD_DATA = 8'h00;
  logic       LCD_EN   = 1'b0;
  logic       LCD_RS   = 1'b0;
  logic       LCD_RW   = 1'b0;
  logic       LCD_ON   = 1'b1;
  logic [4:0] RD_ADDR  = 5'd0;
  logic [7:0] RD_CHAR;
  logic [4:0] CURSOR;
  logic       DISP_ON;
  logic       BUSY;
  logic       CMD_VALID;
  logic [8:0] CMD_CODE;
  logic [3:0] ERR;

  lcd_receptor #(
    .CLEAR_CYCLES (ClearCycles),
    .CMD_CYCLES   (CmdCycles)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .LCD_DATA  (LCD_DATA),
    .LCD_EN    (LCD_EN),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_ON    (LCD_ON),
    .RD_ADDR   (RD_ADDR),
    .RD_CHAR   (RD_CHAR),
    .CURSOR    (CURSOR),
    .DISP_ON   (DISP_ON),
    .BUSY      (BUSY),
    .CMD_VALID (CMD_VALID),
    .CMD_CODE  (CMD_CODE),
    .ERR       (ERR)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int m_valid  = 0;

  logic [7:0] m_cells [32];
  int         m_cur;
  bit         m_inc;
  bit         m_disp;
  logic [3:0] m_err;

  always @(negedge CLOCK_50) if (CMD_VALID === 1'b1) n_valid++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_cells[i]) m_cells[i] = 8'h20;
    m_cur  = 0;
    m_inc  = 1'b1;
    m_disp = 1'b0;
    m_err  = 4'h0;
  endfunction

  // Display behaviour from the instruction-set description, written as plain arithmetic.
  function automatic void model_apply(input logic rs, input logic [7:0] d);
    int a;
    a = int'(d);
    if (rs) begin
      m_cells[m_cur] = d;
      m_cur = m_inc ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
    end else if (a == 1) begin
      foreach (m_cells[i]) m_cells[i] = 8'h20;
      m_cur = 0;
      m_inc = 1'b1;
    end else if (a == 2 || a == 3) begin
      m_cur = 0;
    end else if (a >= 4 && a <= 7) begin
      m_inc = d[1];
      if (d[0]) m_err[2] = 1'b1;
    end else if (a >= 8 && a <= 15) begin
      m_disp = d[2];
    end else if (a >= 32 && a <= 63) begin
      if (!d[4]) m_err[2] = 1'b1;
    end else if (a >= 64 && a <= 127) begin
      m_err[2] = 1'b1;
    end else if (a >= 128) begin
      a = a - 128;
      if (a < 16) m_cur = a;
      else if (a >= 64 && a < 80) m_cur = 16 + (a - 64);
      else m_err[3] = 1'b1;
    end
  endfunction

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hold);
    @(negedge CLOCK_50);
    LCD_RS   = rs;
    LCD_RW   = rw;
    LCD_DATA = d;
    LCD_EN   = 1'b1;
    repeat (hold) @(negedge CLOCK_50);
    LCD_EN = 1'b0;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic rs, input logic rw, input logic [7:0] d, input int hold,
                      input bit busy_ctx, input bit wait_done);
    bit acc;
    bit slow;
    int n;
    acc  = LCD_ON && !busy_ctx && !rw;
    slow = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    strobe(rs, rw, d, hold);
    if (LCD_ON && busy_ctx) m_err[0] = 1'b1;
    else if (LCD_ON && rw) m_err[1] = 1'b1;
    check("cmd_valid", 32'(CMD_VALID), 32'(acc));
    if (acc) begin
      m_valid++;
      model_apply(rs, d);
      check("cmd_code", 32'(CMD_CODE), 32'({rs, d}));
      check("busy_t1", 32'(BUSY), 32'(1));
      if (!(slow && d == 8'h01)) check("cursor_t1", 32'(CURSOR), 32'(m_cur));
      check("disp_t1", 32'(DISP_ON), 32'(m_disp));
      if (wait_done) begin
        n = 0;
        while (BUSY === 1'b1 && n < 1000) begin
          n++;
          @(posedge CLOCK_50);
          #1;
        end
        check("busy_len", 32'(n), slow ? 32'(ClearCycles) : 32'(CmdCycles));
        check("cursor", 32'(CURSOR), 32'(m_cur));
      end
    end
    check("err", 32'(ERR), 32'(m_err));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 1000) begin
      n++;
      @(posedge CLOCK_50);
      #1;
    end
    check("idle", 32'(BUSY), 32'(0));
  endtask

  task automatic check_cells(input string tag);
    for (int a = 0; a < 32; a++) begin
      @(negedge CLOCK_50);
      RD_ADDR = 5'(a);
      @(posedge CLOCK_50);
      #1;
      check($sformatf("%s_cell%0d", tag, a), 32'(RD_CHAR), 32'(m_cells[a]));
    end
  endtask

  task automatic write_text(input string s);
    for (int i = 0; i < s.len(); i++) send(1'b1, 1'b0, s[i], 2, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 32'(0));
    check({tag, "_valid"}, 32'(CMD_VALID), 32'(0));
    check({tag, "_code"}, 32'(CMD_CODE), 32'(0));
    check({tag, "_err"}, 32'(ERR), 32'(0));
    check({tag, "_cursor"}, 32'(CURSOR), 32'(0));
    check({tag, "_disp"}, 32'(DISP_ON), 32'(0));
    check({tag, "_rdchar"}, 32'(RD_CHAR), 32'(8'h20));
  endtask

  initial begin
    logic [7:0] d;
    int r;
    model_reset();

    // Reset state.
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_outputs("reset");
    @(negedge CLOCK_50);
    RESET = 1'b0;
    check_cells("reset");

    // Init sequence.
    send(1'b0, 1'b0, 8'h38, 4, 1'b0, 1'b1);
    send(1'b0, 1'b0, 8'h0C, 4, 1'b0, 1'b1);
    send(1'b0, 1'b0, 8'h01, 4, 1'b0, 1'b1);
    check("init_disp_on", 32'(DISP_ON), 32'(1));
    check("init_pulses", 32'(n_valid), 32'(3));
    check_cells("init");

    // Two-line text.
    send(1'b0, 1'b0, 8'h83, 2, 1'b0, 1'b1);
    write_text("Lab de SO");
    send(1'b0, 1'b0, 8'hC0, 2, 1'b0, 1'b1);
    write_text("SW0");
    check("text_cursor19", 32'(CURSOR), 32'(19));
    check_cells("text");

    // Line wrap and decrement wrap.
    send(1'b0, 1'b0, 8'h80, 1, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) send(1'b1, 1'b0, 8'h41 + 8'(i), 1, 1'b0, 1'b1);
    check("wrap_cursor17", 32'(CURSOR), 32'(17));
    send(1'b0, 1'b0, 8'h04, 1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 8'h80, 1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 8'h7A, 1, 1'b0, 1'b1);
    check("dec_cursor31", 32'(CURSOR), 32'(31));
    send(1'b0, 1'b0, 8'h06, 1, 1'b0, 1'b1);
    check_cells("wrap");

    // Random legal traffic.
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55) d = 8'($urandom_range(8'h21, 8'h7E));
      else if (r < 70) d = 8'h80 | ($urandom_range(0, 1) != 0 ? 8'h40 : 8'h00)
                            | 8'($urandom_range(0, 15));
      else if (r < 80) d = 8'h04 | ($urandom_range(0, 1) != 0 ? 8'h02 : 8'h00);
      else if (r < 88) d = 8'h08 | 8'($urandom_range(0, 7));
      else if (r < 94) d = 8'h10 | 8'($urandom_range(0, 15));
      else d = 8'h02 | 8'($urandom_range(0, 1));
      send(r < 55 ? 1'b1 : 1'b0, 1'b0, d, int'($urandom_range(1, 4)), 1'b0, 1'b1);
    end
    check("rand_pulses", 32'(n_valid), 32'(m_valid));
    check_cells("rand");

    // Strobe during the busy window of a clear.
    send(1'b0, 1'b0, 8'h01, 2, 1'b0, 1'b0);
    repeat (8) @(posedge CLOCK_50);
    send(1'b1, 1'b0, 8'h58, 2, 1'b1, 1'b0);
    wait_idle();
    check("busy_pulses", 32'(n_valid), 32'(m_valid));
    check_cells("busy");

    // Error flags.
    send(1'b0, 1'b1, 8'h06, 2, 1'b0, 1'b1);
    send(1'b0, 1'b0, 8'h28, 2, 1'b0, 1'b1);
    send(1'b0, 1'b0, 8'h85, 2, 1'b0, 1'b1);
    send(1'b0, 1'b0, 8'h90, 2, 1'b0, 1'b1);
    check("bad_addr_cursor5", 32'(CURSOR), 32'(5));
    LCD_ON = 1'b0;
    send(1'b1, 1'b0, 8'h5A, 2, 1'b0, 1'b1);
    send(1'b0, 1'b0, 8'h01, 2, 1'b0, 1'b1);
    LCD_ON = 1'b1;
    check("off_pulses", 32'(n_valid), 32'(m_valid));
    check_cells("off");

    // Reset in the middle of a clear sweep.
    write_text("XYZW");
    send(1'b0, 1'b0, 8'hC3, 1, 1'b0, 1'b1);
    write_text("qrst");
    send(1'b0, 1'b0, 8'h01, 2, 1'b0, 1'b0);
    repeat (10) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b1;
    @(posedge CLOCK_50);
    #1;
    model_reset();
    check_reset_outputs("midreset");
    @(negedge CLOCK_50);
    RESET = 1'b0;
    check_cells("midreset");
    send(1'b1, 1'b0, 8'h61, 2, 1'b0, 1'b1);
    check_cells("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_receptor.md
# lcd_receptor

Behavioural/synthesizable responder for the HD44780-style character LCD bus driven by our LCD writers. It observes LCD_DATA/LCD_RS/LCD_RW/LCD_EN, decodes each strobe into a command or a data write, and keeps a 2×16 character shadow of the display plus cursor, display-on and busy state. It sits on the same LCD pins as the writer. It serves as the on-chip mirror for debug readout and as the checker model in writer testbenches.

## Interface
Parameters:
- CLEAR_CYCLES, 82000: busy duration after clear/home commands (1.64 ms at 50 MHz).
- CMD_CYCLES, 2000: busy duration after any other accepted command or data write (40 µs).

Ports:
- CLOCK_50  in  1  system clock, single clock domain.
- RESET  in  1  synchronous, active-high reset.
- LCD_DATA  in  8  bus data.
- LCD_EN  in  1  enable strobe; transfer latched on falling edge.
- LCD_RS  in  1  0 = instruction, 1 = data.
- LCD_RW  in  1  0 = write; 1 = read (unsupported).
- LCD_ON  in  1  0 = module powered off; all strobes ignored.
- RD_ADDR  in  5  shadow read address: 0–15 line 1, 16–31 line 2.
- RD_CHAR  out  8  character at RD_ADDR, registered.
- CURSOR  out  5  current write position, same encoding as RD_ADDR.
- DISP_ON  out  1  display-on bit (D) from the last display-control command.
- BUSY  out  1  high while an accepted transfer is executing.
- CMD_VALID  out  1  one-cycle pulse per accepted transfer.
- CMD_CODE  out  9  {RS, DATA} of the accepted transfer; valid with CMD_VALID.
- ERR  out  4  sticky flags: [0] strobe while busy, [1] RW=1, [2] unsupported command, [3] bad DDRAM address.

## Operation
- Edge detect: en_q <= LCD_EN each cycle; LCD_DATA/RS/RW are registered alongside it. A fall is en_q=1 and LCD_EN=0 while LCD_ON=1. The transfer uses the registered bus values, i.e. the values present during the last EN-high cycle.
- Fall while BUSY=1: transfer discarded, ERR[0] set, no CMD_VALID.
- Fall with RW=1: discarded, ERR[1] set.
- Accepted transfer: CMD_VALID pulses, then decode:
  - RS=1, data: cell[CURSOR] <= DATA; CURSOR moves by the entry mode. Increment: 15→16, 31→0. Decrement: 0→31, 16→15. BUSY for CMD_CYCLES.
  - 0x01, clear: sweep writes 0x20 to cells 0..31, one cell per cycle (32 cycles). CURSOR=0; entry mode set to increment. BUSY for CLEAR_CYCLES.
  - 0x02/0x03, home: CURSOR=0, contents kept. BUSY for CLEAR_CYCLES.
  - 0x04–0x07, entry mode: bit1 = I/D. Bit0 (shift) is ignored and sets ERR[2] if 1.
  - 0x08–0x0F, display control: DISP_ON = bit2; cursor/blink bits ignored.
  - 0x10–0x1F, shift: no effect.
  - 0x20–0x3F, function set: bit4 = 0 (4-bit mode) sets ERR[2]; otherwise no effect.
  - 0x40–0x7F, CGRAM address: ERR[2].
  - 0x80|A, DDRAM address: A=0x00–0x0F → CURSOR=A. A=0x40–0x4F → CURSOR=16+(A−0x40). Any other A → CURSOR unchanged, ERR[3] set.
  - All accepted commands other than clear/home are busy for CMD_CYCLES, including those that raise ERR[2]/ERR[3].
- FSM: IDLE → EXEC (one cycle, applies the decode) → WAIT (busy countdown), then back to IDLE. Clear goes IDLE → EXEC → CLEAR_SWEEP (32 cycles) → WAIT.
- LCD_ON=0: strobes are ignored, but state is not cleared.

## Timing
- Reset values: all cells 0x20, CURSOR=0, increment mode, DISP_ON=0, BUSY=0, CMD_VALID=0, CMD_CODE=0, ERR=0, RD_CHAR=0x20 on the first cycle after reset, FSM=IDLE. Reset mid-sweep or mid-busy aborts immediately.
- Timeline with the fall seen at cycle t:
  - t+1: CMD_VALID=1, BUSY=1; shadow/CURSOR/DISP_ON updates for non-clear commands are visible.
  - Busy period: BUSY stays high for exactly the parameter count of cycles starting at t+1. The clear sweep runs inside the CLEAR_CYCLES window.
  - Falls detected from t+1 through the last BUSY=1 cycle are errors. A fall in the first cycle with BUSY=0 is accepted.
- RD_CHAR: one-cycle read latency. A read and write to the same cell in the same cycle returns the old value.
- ERR bits clear only on RESET.

## Structure
- Package lcd_pkg holds:
  - command codes/masks (CLR, HOME, ENTRY, DISPCTL, SHIFT, FUNCSET, CGRAM, DDRAM);
  - SPACE=8'h20, LINE2_BASE=7'h40;
  - the ERR bit indices;
  - the FSM state enum.
- Sub-module lcd_ddram: 32×8 register array with one write port, a registered read port and a synchronous reset fill to 0x20.

## Test plan
- Init sequence: 0x38, 0x0C, 0x01 each held EN-high 4 cycles with ≥CLEAR_CYCLES gaps → DISP_ON=1, all cells 0x20, CURSOR=0, ERR=0, three CMD_VALID pulses.
- Write "Lab de SO" after 0x83, then 0xC0, then "SW0" → cells 3..11 match the text, cells 16..18 = "SW0", CURSOR=19.
- Write 16 chars from cursor 0, then one more → 17th char lands in cell 16; 0x04 then data at CURSOR=0 → CURSOR=31.
- Strobe issued 10 cycles after a 0x01 → ERR[0]=1, no CMD_VALID, shadow unchanged.
- Error cases:
  - RW=1 strobe → ERR[1].
  - 0x28 → ERR[2].
  - 0x90 → ERR[3], CURSOR unchanged.
  - LCD_ON=0 strobe → no effect at all.
- RESET asserted during a clear sweep at cell 10 → next cycle all outputs at reset values, cells all 0x20, BUSY=0.
